// File: rtl/mux8_to_1.sv
// Registered 8-way selector for the mini CPU datapath: one of seven sources
// (or a fixed default for the unused code) is captured into Y every clock.
module mux8_to_1 #(
   parameter int unsigned WIDTH         = 8,
   parameter logic [63:0] DEFAULT_VALUE = 64'd0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] E,
   input  logic [WIDTH-1:0] F,
   input  logic [WIDTH-1:0] G,
   input  logic [2:0]       Sel,
   output logic [WIDTH-1:0] Y
);

   localparam int unsigned   SEL_W     = 3;
   localparam logic [WIDTH-1:0] DEFAULT_Y = WIDTH'(DEFAULT_VALUE);

   logic [WIDTH-1:0] y_d;
   logic [WIDTH-1:0] y_q;

   // Source selection; the default branch also absorbs X/Z on Sel.
   always_comb begin
      y_d = DEFAULT_Y;
      case (Sel)
         SEL_W'(0): y_d = A;
         SEL_W'(1): y_d = B;
         SEL_W'(2): y_d = C;
         SEL_W'(3): y_d = D;
         SEL_W'(4): y_d = E;
         SEL_W'(5): y_d = F;
         SEL_W'(6): y_d = G;
         default:   y_d = DEFAULT_Y;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign Y = y_q;

endmodule

// File: tb/tb_mux8_to_1.sv
// Self-checking bench for mux8_to_1: directed scenarios plus randomized
// traffic against an array-indexed reference model with async reset pulses.
module tb_mux8_to_1;

   localparam int unsigned WIDTH = 8;

   logic             Clk;
   logic             Reset;
   logic [WIDTH-1:0] src [7];
   logic [2:0]       Sel;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] exp_y;

   int n_cmp;
   int n_err;

   mux8_to_1 #(.WIDTH(WIDTH), .DEFAULT_VALUE(64'd0)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .A     (src[0]),
      .B     (src[1]),
      .C     (src[2]),
      .D     (src[3]),
      .E     (src[4]),
      .F     (src[5]),
      .G     (src[6]),
      .Sel   (Sel),
      .Y     (Y)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference: code 7 selects the default constant, otherwise index the sources.
   function automatic logic [WIDTH-1:0] model_y(input logic [2:0] s);
      if (s == 3'd7) return '0;
      return src[int'(s)];
   endfunction

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic set_sources(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] step);
      for (int i = 0; i < 7; i++) src[i] = v0 + WIDTH'(i) * step;
   endtask

   // Capture the model value for the current inputs, then check after the edge.
   task automatic edge_check(input string tag);
      exp_y = model_y(Sel);
      @(posedge Clk);
      #1;
      check(tag, Y, exp_y);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      Reset = 1'b1;
      Sel   = 3'd3;
      set_sources(8'd0, 8'd1);
      #2;
      check("reset_init", Y, 8'h00);
      @(posedge Clk); #1;
      check("reset_held_edge", Y, 8'h00);
      @(negedge Clk);
      Reset = 1'b0;
      edge_check("first_load");

      // Asynchronous reset mid-cycle, held across an edge.
      #2;
      Reset = 1'b1;
      #1;
      check("reset_async", Y, 8'h00);
      @(posedge Clk); #1;
      check("reset_hold", Y, 8'h00);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("reset_release_no_edge", Y, 8'h00);
      edge_check("reset_reload");

      // Sweep every real source.
      for (int s = 0; s < 7; s++) begin
         @(negedge Clk);
         Sel = 3'(s);
         edge_check($sformatf("sweep_%0d", s));
      end

      // Unused code selects the default.
      @(negedge Clk);
      set_sources(8'hFF, 8'h00);
      Sel = 3'd7;
      edge_check("sel7_default");
      check("sel7_literal", Y, 8'h00);

      // Isolation of non-selected inputs.
      @(negedge Clk);
      Sel    = 3'd2;
      src[2] = 8'h5A;
      edge_check("iso_load");
      @(negedge Clk);
      for (int i = 0; i < 7; i++) if (i != 2) src[i] = 8'hA5;
      edge_check("iso_hold");
      check("iso_hold_literal", Y, 8'h5A);
      @(negedge Clk);
      src[2] = 8'h3C;
      edge_check("iso_change");

      // Simultaneous select and data change.
      @(negedge Clk);
      set_sources(8'd0, 8'd1);
      Sel = 3'd4;
      edge_check("simul_pre");
      @(negedge Clk);
      Sel    = 3'd6;
      src[6] = 8'h81;
      #1;
      check("simul_before_edge", Y, 8'h04);
      edge_check("simul_after");
      check("simul_literal", Y, 8'h81);

      // Reset pulse between edges mid-sweep.
      @(negedge Clk);
      set_sources(8'd0, 8'd1);
      Sel = 3'd5;
      edge_check("midstream_pre");
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      check("midstream_reset", Y, 8'h00);
      #1;
      Reset = 1'b0;
      edge_check("midstream_reload");
      check("midstream_literal", Y, 8'h05);

      // Randomized traffic with occasional async reset pulses.
      for (int n = 0; n < 300; n++) begin
         @(negedge Clk);
         for (int i = 0; i < 7; i++) src[i] = WIDTH'($urandom);
         Sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) begin
            Reset = 1'b1;
            #1;
            check("rand_reset", Y, 8'h00);
            #1;
            Reset = 1'b0;
         end
         edge_check("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux8_to_1.md
Name: mux8_to_1

Overview:
- Registered 8-way selector for the 8-bit mini CPU datapath.
- Seven 8-bit data sources (A..G) feed it, and a 3-bit Sel chooses one. Sel code 7 is unused and selects a fixed default constant.
- The selected value is captured on the rising clock edge and driven on Y. Y feeds downstream datapath registers and the ALU operand path.

Parameters:
- WIDTH, 8, bit width of each data input and of Y.
- DEFAULT_VALUE, 0, value (WIDTH bits) selected when Sel = 7.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- A  input  WIDTH  data source, Sel = 0.
- B  input  WIDTH  data source, Sel = 1.
- C  input  WIDTH  data source, Sel = 2.
- D  input  WIDTH  data source, Sel = 3.
- E  input  WIDTH  data source, Sel = 4.
- F  input  WIDTH  data source, Sel = 5.
- G  input  WIDTH  data source, Sel = 6.
- Sel  input  3  source select.
- Y  output  WIDTH  registered selected value.

Behaviour:
- Clocking and reset:
  - Single clock domain, Clk.
  - Reset is asynchronous and active-high.
  - While Reset = 1, Y = 0 immediately, independent of Clk. Y stays 0 for as long as Reset is held.
  - On Reset deassertion, the first rising Clk edge loads normally.
- Selection, evaluated combinationally from the current inputs:
  - Sel 0→A, 1→B, 2→C, 3→D, 4→E, 5→F, 6→G.
  - Sel 7→DEFAULT_VALUE.
  - Any X/Z on Sel must not propagate as a latch. The implementation uses a full case with a default branch yielding DEFAULT_VALUE.
- Latency:
  - Y ← selected value on every rising Clk edge while Reset = 0.
  - Latency is exactly 1 cycle from Sel/data change to Y change.
  - No enable input: the register loads every cycle.
- Data changes:
  - Changes on non-selected inputs have no effect on Y.
  - A change on the selected input appears on Y at the next rising edge.
- Simultaneous Sel and data change before an edge: Y takes the new Sel applied to the new data.
- Reset mid-operation: Y clears to 0 asynchronously. The pre-reset selection is not retained.
- Width rules:
  - No arithmetic; bit-exact pass-through of the full WIDTH.
  - No sign or zero extension.
  - DEFAULT_VALUE is truncated or zero-extended to WIDTH.
- No combinational path from any input to Y. Y comes only from the output register.

Test Plan:
- Reset: drive A..G = 0..6 and Sel = 3, assert Reset mid-cycle → Y = 0 immediately without a clock edge. Y holds 0 until Reset drops and a clock edge occurs.
- Sweep: A=0, B=1, C=2, D=3, E=4, F=5, G=6; step Sel 0..6, one value per cycle → Y = 0,1,2,3,4,5,6, each one cycle after Sel is applied.
- Unused code: Sel = 7 with A..G = 8'hFF → Y = 8'h00 (DEFAULT_VALUE) after one edge.
- Isolation: Sel = 2, C = 8'h5A, then toggle A, B, D–G to 8'hA5 → Y stays 8'h5A. Change C to 8'h3C → Y = 8'h3C at the next edge.
- Simultaneous change: Sel 4→6 and G 6→8'h81 in the same cycle → Y = 8'h81 at the next edge. Before that edge, Y keeps the E value.
- Reset mid-stream: during the sweep, pulse Reset between edges while Sel = 5 → Y = 0 during reset. Y = F (5) on the first edge after release.
